// File: rtl/led_blink_arbiter.sv
// led_blink_arbiter: round-robin sharing of one LED among NREQ requesters, each playing an N-blink code then a dark gap.
// Define FIXED_PRIO_EN to make the lowest-index request always win instead of round-robin.
module led_blink_arbiter #(
  parameter int CLK_HZ  = 27000000,
  parameter int TICK_HZ = 1000,
  parameter int NREQ    = 4,
  parameter int CNT_W   = 4,
  parameter int ON_T    = 200,
  parameter int OFF_T   = 200,
  parameter int GAP_T   = 1000,
  localparam int GW     = $clog2(NREQ)
) (
  input  logic                    CLK,
  input  logic                    RESETn,
  input  logic [NREQ-1:0]         iReq,
  input  logic [NREQ*CNT_W-1:0]   iCount,
  output logic [NREQ-1:0]         oAck,
  output logic [GW-1:0]           oGrantId,
  output logic                    oBusy,
  output logic                    oDone,
  output logic                    oLED
);
  localparam int DIV  = CLK_HZ / TICK_HZ;
  localparam int PW   = DIV > 1 ? $clog2(DIV) : 1;
  localparam int TMAX = ON_T > OFF_T ? (ON_T > GAP_T ? ON_T : GAP_T) : (OFF_T > GAP_T ? OFF_T : GAP_T);
  localparam int TW   = TMAX > 1 ? $clog2(TMAX) : 1;
  typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;
  state_t           state, nxt;
  logic [PW-1:0]    pre;
  logic [TW-1:0]    ph;
  logic [CNT_W-1:0] rem, cnt_g;
  logic [GW-1:0]    g, base;
  logic             found, tick, ph_done, grant, entry;
  int               j, tlim;
`ifndef FIXED_PRIO_EN
  logic [GW-1:0]    ptr;
  assign base = ptr;
`else
  assign base = '0;
`endif
  // Scan downward so the requester closest after base is the last (winning) assignment.
  always_comb begin
    found = 1'b0;
    g = '0;
    j = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = int'(base) + i;
      if (j >= NREQ) j = j - NREQ;
      if (iReq[j]) begin
        found = 1'b1;
        g = GW'(j);
      end
    end
  end
  always_comb begin
    cnt_g   = iCount[int'(g)*CNT_W +: CNT_W];
    grant   = (state == IDLE) && found;
    tick    = pre == PW'(DIV - 1);
    tlim    = state == ON ? ON_T : state == OFF ? OFF_T : GAP_T;
    ph_done = tick && (ph == TW'(tlim - 1));
    nxt     = state;
    case (state)
      IDLE:    nxt = grant ? (cnt_g != '0 ? ON : GAP) : IDLE;
      ON:      nxt = ph_done ? OFF : ON;
      OFF:     nxt = ph_done ? (rem != '0 ? ON : GAP) : OFF;
      default: nxt = ph_done ? IDLE : GAP;
    endcase
    entry = nxt != state;
  end
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state    <= IDLE;
      pre      <= '0;
      ph       <= '0;
      rem      <= '0;
      oAck     <= '0;
      oGrantId <= '0;
      oBusy    <= 1'b0;
      oDone    <= 1'b0;
      oLED     <= 1'b0;
`ifndef FIXED_PRIO_EN
      ptr      <= '0;
`endif
    end else begin
      state <= nxt;
      pre   <= (entry || tick) ? '0 : pre + 1'b1;
      ph    <= (entry || state == IDLE) ? '0 : tick ? ph + 1'b1 : ph;
      rem   <= grant ? cnt_g : (state == ON && ph_done && rem != '0) ? rem - 1'b1 : rem;
      oAck  <= grant ? NREQ'(1) << g : '0;
      oBusy <= nxt != IDLE;
      oDone <= (state == GAP) && (nxt == IDLE);
      oLED  <= nxt == ON;
      if (grant) begin
        oGrantId <= g;
`ifndef FIXED_PRIO_EN
        ptr      <= (int'(g) == NREQ - 1) ? '0 : g + 1'b1;
`endif
      end
    end
  end
endmodule

// File: tb/tb_led_blink_arbiter.sv
// tb_led_blink_arbiter: directed checks of grant order, blink pattern, timing and reset abort.
module tb_led_blink_arbiter;
  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic [3:0]  iReq = '0;
  logic [15:0] iCount = '0;
  logic [3:0]  oAck;
  logic [1:0]  oGrantId;
  logic        oBusy, oDone, oLED;
  int          n_cmp = 0, n_bad = 0;

  led_blink_arbiter #(.CLK_HZ(1), .TICK_HZ(1), .NREQ(4), .CNT_W(4), .ON_T(2), .OFF_T(2), .GAP_T(3)) dut (
    .CLK(CLK), .RESETn(RESETn), .iReq(iReq), .iCount(iCount), .oAck(oAck),
    .oGrantId(oGrantId), .oBusy(oBusy), .oDone(oDone), .oLED(oLED));

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (oAck == '0 && n < 40);
    if (oAck == '0) chk("ack_timeout", 32'(n), 32'd0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (oBusy && n < 60) begin
      step();
      n++;
    end
    chk("idle_reached", 32'(oBusy), 32'd0);
    step();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESETn = 1'b0;
    iReq = '0;
    step();
    RESETn = 1'b1;
    step();
  endtask

  task automatic play(input string tag, input int len, input logic [31:0] exp_pat);
    logic [31:0] pat = '0;
    int busy = 0;
    for (int i = 0; i < len; i++) begin
      pat = {pat[30:0], oLED};
      busy += int'(oBusy);
      if (oDone) chk({tag, "_early_done"}, 32'(oDone), 32'd0);
      step();
    end
    chk({tag, "_led"}, pat, exp_pat);
    chk({tag, "_busy_len"}, 32'(busy), 32'(len));
    chk({tag, "_done"}, 32'(oDone), 32'd1);
    chk({tag, "_busy_end"}, 32'(oBusy), 32'd0);
    step();
    chk({tag, "_done_1cyc"}, 32'(oDone), 32'd0);
  endtask

  initial begin
    int n;
    int ids[4];
    // reset with random inputs
    iReq = 4'($urandom);
    iCount = 16'($urandom);
    repeat (3) step();
    chk("rst_outs", {oAck, 2'(oGrantId), oBusy, oDone, oLED}, 32'd0);
    iReq = '0;
    RESETn = 1'b1;
    n = 0;
    repeat (5) begin
      step();
      n += int'(oBusy);
    end
    chk("idle_busy", 32'(n), 32'd0);

    // single requester, count 3
    iReq = 4'b0001;
    iCount = 16'h0003;
    step();
    chk("t3_ack", 32'(oAck), 32'h1);
    chk("t3_id", 32'(oGrantId), 32'd0);
    iReq = '0;
    play("t3", 15, 32'b110011001100000);

    // simultaneous requesters 1 and 2, rr pointer now at 1
    iReq = 4'b0110;
    iCount = 16'h1111;
    step();
    chk("t4_ack1", 32'(oAck), 32'h2);
    chk("t4_id1", 32'(oGrantId), 32'd1);
    iReq = 4'b0100;
    wait_ack(n);
    chk("t4_gap", 32'(n), 32'd8);
    chk("t4_ack2", 32'(oAck), 32'h4);
    chk("t4_id2", 32'(oGrantId), 32'd2);
    iReq = '0;
    wait_idle();

    // held requesters 0 and 3 from reset
    do_reset();
    iReq = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      wait_ack(n);
      ids[k] = int'(oGrantId);
    end
    iReq = '0;
`ifdef FIXED_PRIO_EN
    chk("t5_ids", {8'(ids[0]), 8'(ids[1]), 8'(ids[2]), 8'(ids[3])}, 32'h00000000);
`else
    chk("t5_ids", {8'(ids[0]), 8'(ids[1]), 8'(ids[2]), 8'(ids[3])}, 32'h00030003);
`endif
    wait_idle();

    // count zero goes straight to the gap
    do_reset();
    iReq = 4'b0100;
    iCount = 16'h0011;
    wait_ack(n);
    chk("t6_ack", 32'(oAck), 32'h4);
    chk("t6_id", 32'(oGrantId), 32'd2);
    iReq = '0;
    play("t6", 3, 32'b000);

    // reset during ON aborts; pending requester 1 starts cleanly after
    do_reset();
    iReq = 4'b0001;
    iCount = 16'h0025;
    wait_ack(n);
    iReq = 4'b0010;
    chk("t7_led_on", 32'(oLED), 32'd1);
    RESETn = 1'b0;
    #1;
    chk("t7_async", {oAck, 2'(oGrantId), oBusy, oDone, oLED}, 32'd0);
    n = 0;
    repeat (3) begin
      step();
      n += int'(oDone);
    end
    RESETn = 1'b1;
    wait_ack(n);
    chk("t7_ack", 32'(oAck), 32'h2);
    chk("t7_id", 32'(oGrantId), 32'd1);
    iReq = '0;
    play("t7", 11, 32'b11001100000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
